// File: rtl/flash_ctrl_pkg.sv
// Shared definitions for the SPI flash read controller: FSM encoding,
// flash opcodes and the address-byte helper.
package flash_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4,
        ST_GAP  = 3'd5
    } state_e;

    localparam logic [7:0] SPI_READ_CMD = 8'h03;
    localparam logic [7:0] SPI_READ_FST = 8'h0B;
    localparam int         ADDR_BYTES   = 3;

    // Address bytes go out most significant first.
    function automatic logic [7:0] addr_byte(input logic [23:0] addr, input logic [2:0] idx);
        case (idx)
            3'd0:    addr_byte = addr[23:16];
            3'd1:    addr_byte = addr[15:8];
            default: addr_byte = addr[7:0];
        endcase
    endfunction

endpackage

// File: rtl/spi_flash_read_arb_if.sv
// Requester and SPI byte-engine signals of the flash read arbiter.
// Handshakes: reqN_valid is held with reqN_addr until a one-cycle reqN_ready
// pulse accepts it; respN_valid, spi_tx_dv and spi_rx_dv are one-cycle pulses
// that qualify their data in that same cycle; spi_tx_dv is only issued while
// spi_tx_ready is high and no earlier byte still awaits its spi_rx_dv.
interface spi_flash_read_arb_if;
    logic        req0_valid;
    logic [23:0] req0_addr;
    logic        req0_ready;
    logic        resp0_valid;
    logic [31:0] resp0_data;
    logic        req1_valid;
    logic [23:0] req1_addr;
    logic        req1_ready;
    logic        resp1_valid;
    logic [31:0] resp1_data;
    logic [7:0]  spi_tx_byte;
    logic        spi_tx_dv;
    logic        spi_tx_ready;
    logic        spi_rx_dv;
    logic [7:0]  spi_rx_byte;
    logic        cs_n;
    logic        busy;

    modport slave (
        input  req0_valid, req0_addr, req1_valid, req1_addr,
        input  spi_tx_ready, spi_rx_dv, spi_rx_byte,
        output req0_ready, resp0_valid, resp0_data,
        output req1_ready, resp1_valid, resp1_data,
        output spi_tx_byte, spi_tx_dv, cs_n, busy
    );

    modport master (
        output req0_valid, req0_addr, req1_valid, req1_addr,
        output spi_tx_ready, spi_rx_dv, spi_rx_byte,
        input  req0_ready, resp0_valid, resp0_data,
        input  req1_ready, resp1_valid, resp1_data,
        input  spi_tx_byte, spi_tx_dv, cs_n, busy
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. On a tie the port not served last wins; the
// last-served register resets to port 1 so port 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic       grant_o,
    output logic       any_o
);
    logic last_q;
    logic last_d;

    // Grant selection and last-served update on an accepted grant.
    always_comb begin
        if (req_i == 2'b11) begin
            grant_o = ~last_q;
        end else begin
            grant_o = req_i[1];
        end
        any_o  = |req_i;
        last_d = take_i ? grant_o : last_q;
    end

    // Last-served register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/spi_flash_read_arb.sv
// Arbitrates two read requesters onto one SPI flash: issues the read opcode,
// three address bytes and dummy bytes one at a time to a byte engine, and
// assembles the returned data little-endian into a 32-bit response.
module spi_flash_read_arb
    import flash_ctrl_pkg::*;
#(
    parameter logic [7:0] CMD_BYTE   = SPI_READ_CMD,
    parameter int         DATA_BYTES = 4,
    parameter int         CS_IDLE    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_flash_read_arb_if.slave  bus,
    output state_e               state_o
);
    localparam logic [2:0] ADDR_LAST = 3'(ADDR_BYTES - 1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BYTES - 1);
    localparam logic [2:0] GAP_LAST  = 3'(CS_IDLE - 1);

    state_e      state_q;
    logic        port_q;
    logic [23:0] addr_q;
    logic [2:0]  cnt_q;
    logic [2:0]  gap_q;
    logic        pend_q;
    logic [31:0] word_q;
    logic        cs_n_q;
    logic        tx_dv_q;
    logic [7:0]  tx_byte_q;
    logic [1:0]  ready_q;
    logic [1:0]  resp_valid_q;
    logic [31:0] resp0_data_q;
    logic [31:0] resp1_data_q;

    logic        arb_grant;
    logic        arb_any;
    logic        arb_take;
    logic [7:0]  byte_d;
    logic [2:0]  last_cnt;
    logic [31:0] word_d;

    assign arb_take = (state_q == ST_IDLE) && arb_any;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   ({bus.req1_valid, bus.req0_valid}),
        .take_i  (arb_take),
        .grant_o (arb_grant),
        .any_o   (arb_any)
    );

    // Byte to send in the current phase, last count of the phase, and the
    // data word with the incoming byte merged at the current data position.
    always_comb begin
        byte_d   = 8'h00;
        last_cnt = 3'd0;
        word_d   = word_q;
        word_d[{cnt_q[1:0], 3'b000} +: 8] = bus.spi_rx_byte;
        case (state_q)
            ST_CMD:  byte_d = CMD_BYTE;
            ST_ADDR: begin
                byte_d   = addr_byte(addr_q, cnt_q);
                last_cnt = ADDR_LAST;
            end
            ST_DATA: last_cnt = DATA_LAST;
            default: ;
        endcase
    end

    // Transaction FSM with all outputs registered; pulses default low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            port_q       <= 1'b0;
            addr_q       <= 24'h000000;
            cnt_q        <= 3'd0;
            gap_q        <= 3'd0;
            pend_q       <= 1'b0;
            word_q       <= 32'h0;
            cs_n_q       <= 1'b1;
            tx_dv_q      <= 1'b0;
            tx_byte_q    <= 8'h00;
            ready_q      <= 2'b00;
            resp_valid_q <= 2'b00;
            resp0_data_q <= 32'h0;
            resp1_data_q <= 32'h0;
        end else begin
            tx_dv_q      <= 1'b0;
            tx_byte_q    <= 8'h00;
            ready_q      <= 2'b00;
            resp_valid_q <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        port_q            <= arb_grant;
                        ready_q[arb_grant] <= 1'b1;
                        addr_q            <= arb_grant ? bus.req1_addr : bus.req0_addr;
                        cnt_q             <= 3'd0;
                        pend_q            <= 1'b0;
                        word_q            <= 32'h0;
                        cs_n_q            <= 1'b0;
                        state_q           <= ST_CMD;
                    end
                end
                ST_CMD, ST_ADDR, ST_DATA: begin
                    if (!pend_q && bus.spi_tx_ready) begin
                        tx_dv_q   <= 1'b1;
                        tx_byte_q <= byte_d;
                        pend_q    <= 1'b1;
                    end else if (pend_q && bus.spi_rx_dv) begin
                        pend_q <= 1'b0;
                        if (state_q == ST_DATA) begin
                            word_q <= word_d;
                        end
                        if (cnt_q == last_cnt) begin
                            cnt_q <= 3'd0;
                            if (state_q == ST_CMD) begin
                                state_q <= ST_ADDR;
                            end else if (state_q == ST_ADDR) begin
                                state_q <= ST_DATA;
                            end else begin
                                state_q              <= ST_DONE;
                                cs_n_q               <= 1'b1;
                                resp_valid_q[port_q] <= 1'b1;
                                if (port_q) begin
                                    resp1_data_q <= word_d;
                                end else begin
                                    resp0_data_q <= word_d;
                                end
                            end
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    gap_q   <= 3'd0;
                    state_q <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        gap_q   <= 3'd0;
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + 3'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req0_ready  = ready_q[0];
    assign bus.req1_ready  = ready_q[1];
    assign bus.resp0_valid = resp_valid_q[0];
    assign bus.resp1_valid = resp_valid_q[1];
    assign bus.resp0_data  = resp0_data_q;
    assign bus.resp1_data  = resp1_data_q;
    assign bus.spi_tx_dv   = tx_dv_q;
    assign bus.spi_tx_byte = tx_byte_q;
    assign bus.cs_n        = cs_n_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign state_o         = state_q;
endmodule

// File: tb/tb_spi_flash_read_arb.sv
// Bench for spi_flash_read_arb: a byte-engine/flash model, a monitor with
// expected MOSI and response queues, and one task per scenario.
module tb_spi_flash_read_arb;
    import flash_ctrl_pkg::*;

    logic   clk;
    logic   rst;
    state_e dbg_state;

    spi_flash_read_arb_if bus();

    spi_flash_read_arb #(
        .CMD_BYTE   (8'h03),
        .DATA_BYTES (4),
        .CS_IDLE    (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (dbg_state)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_mosi_q[$];
    logic [32:0] exp_resp_q[$];
    logic [7:0]  miso_q[$];
    int          grant_log[$];
    logic        stall_hold = 1'b0;
    int          tx_seen = 0;
    int          stall_dv = 0;

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte engine + flash: one byte in flight, random reply latency.
    initial begin : flash_model
        logic       pending;
        int         lat;
        logic [7:0] rsp;
        pending = 1'b0;
        lat = 0;
        rsp = 8'h00;
        bus.spi_tx_ready = 1'b1;
        bus.spi_rx_dv    = 1'b0;
        bus.spi_rx_byte  = 8'h00;
        forever begin
            @(posedge clk); #1;
            bus.spi_rx_dv   = 1'b0;
            bus.spi_rx_byte = 8'h00;
            if (rst) begin
                pending = 1'b0;
            end else if (pending) begin
                if (lat == 0) begin
                    bus.spi_rx_dv   = 1'b1;
                    bus.spi_rx_byte = rsp;
                    pending = 1'b0;
                end else begin
                    lat--;
                end
            end else if (bus.spi_tx_dv) begin
                pending = 1'b1;
                lat = $urandom_range(0, 3);
                rsp = (miso_q.size() > 0) ? miso_q.pop_front() : 8'hEE;
            end
            bus.spi_tx_ready = !pending && !stall_hold && !rst;
        end
    end

    // Monitor: MOSI order, responses, chip-select window and gap.
    initial begin : monitor
        logic        cs_prev;
        logic        win_abort;
        int          win_bytes;
        int          high_cnt;
        logic [7:0]  em;
        logic [32:0] er;
        logic [32:0] act;
        cs_prev = 1'b1;
        win_abort = 1'b0;
        win_bytes = 0;
        high_cnt = 100;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                cs_prev = 1'b1;
                win_abort = 1'b1;
                win_bytes = 0;
                high_cnt = 100;
            end else begin
                if (cs_prev && !bus.cs_n) begin
                    checks++;
                    if (high_cnt < 2) begin
                        errors++;
                        $display("FAIL cs_gap: cs_n high %0d cycles, required >= 2", high_cnt);
                    end
                    win_bytes = 0;
                    win_abort = 1'b0;
                end
                if (!cs_prev && bus.cs_n) begin
                    if (!win_abort) begin
                        checks++;
                        if (win_bytes != 8) begin
                            errors++;
                            $display("FAIL cs_window: %0d bytes while cs_n low, required 8", win_bytes);
                        end
                    end
                    high_cnt = 0;
                end
                if (bus.cs_n) high_cnt++;
                if (bus.spi_tx_dv) begin
                    tx_seen++;
                    win_bytes++;
                    if (stall_hold) stall_dv++;
                    checks++;
                    if (bus.cs_n !== 1'b0) begin
                        errors++;
                        $display("FAIL tx_cs: byte %02h sent with cs_n=%b, required 0", bus.spi_tx_byte, bus.cs_n);
                    end
                    checks++;
                    if (exp_mosi_q.size() == 0) begin
                        errors++;
                        $display("FAIL mosi_extra: unexpected byte %02h", bus.spi_tx_byte);
                    end else begin
                        em = exp_mosi_q.pop_front();
                        if (bus.spi_tx_byte !== em) begin
                            errors++;
                            $display("FAIL mosi: got %02h expected %02h", bus.spi_tx_byte, em);
                        end
                    end
                end
                if (bus.resp0_valid || bus.resp1_valid) begin
                    checks++;
                    act = {bus.resp1_valid, bus.resp1_valid ? bus.resp1_data : bus.resp0_data};
                    if (exp_resp_q.size() == 0) begin
                        errors++;
                        $display("FAIL resp_extra: unexpected response port %0d data %08h", act[32], act[31:0]);
                    end else begin
                        er = exp_resp_q.pop_front();
                        if (bus.resp0_valid && bus.resp1_valid) begin
                            errors++;
                            $display("FAIL resp_both: both resp valids high, expected port %0d", er[32]);
                        end else if (act !== er) begin
                            errors++;
                            $display("FAIL resp: got port %0d data %08h expected port %0d data %08h",
                                     act[32], act[31:0], er[32], er[31:0]);
                        end
                    end
                end
                cs_prev = bus.cs_n;
            end
        end
    end

    // Driver: queue the expected bytes, flash replies and response of one read.
    task automatic push_txn(input logic port, input logic [23:0] addr, input logic [31:0] word);
        exp_mosi_q.push_back(8'h03);
        exp_mosi_q.push_back(addr[23:16]);
        exp_mosi_q.push_back(addr[15:8]);
        exp_mosi_q.push_back(addr[7:0]);
        for (int i = 0; i < 4; i++) exp_mosi_q.push_back(8'h00);
        for (int i = 0; i < 4; i++) miso_q.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < 4; i++) miso_q.push_back(word[i*8 +: 8]);
        exp_resp_q.push_back({port, word});
    endtask

    // Driver: raise a request and hold it until its ready pulse.
    task automatic req_port(input int p, input logic [23:0] a);
        logic got;
        got = 1'b0;
        if (p == 0) begin
            bus.req0_addr = a;
            bus.req0_valid = 1'b1;
        end else begin
            bus.req1_addr = a;
            bus.req1_valid = 1'b1;
        end
        for (int i = 0; i < 500 && !got; i++) begin
            @(posedge clk); #1;
            if ((p == 0) ? bus.req0_ready : bus.req1_ready) got = 1'b1;
        end
        if (p == 0) bus.req0_valid = 1'b0;
        else        bus.req1_valid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL req_ready: port %0d got no ready within 500 cycles", p);
        end else begin
            grant_log.push_back(p);
        end
    endtask

    // Wait until all queued work is consumed and the DUT is idle.
    task automatic wait_drain(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk); #1;
            if (exp_resp_q.size() == 0 && exp_mosi_q.size() == 0 && dbg_state == ST_IDLE) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_%s: %0d responses and %0d bytes still pending, required 0",
                     name, exp_resp_q.size(), exp_mosi_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_addr  = 24'h0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = 24'h0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus.cs_n, bus.busy, bus.spi_tx_dv, bus.spi_tx_byte, bus.req0_ready, bus.req1_ready,
             bus.resp0_valid, bus.resp1_valid} !== {1'b1, 1'b0, 1'b0, 8'h00, 4'b0000}) begin
            errors++;
            $display("FAIL reset_outputs: cs_n=%b busy=%b tx_dv=%b tx_byte=%02h rdy=%b%b rv=%b%b, required 1 0 0 00 00 00",
                     bus.cs_n, bus.busy, bus.spi_tx_dv, bus.spi_tx_byte, bus.req1_ready, bus.req0_ready,
                     bus.resp1_valid, bus.resp0_valid);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: state %0d, required %0d", dbg_state, ST_IDLE);
        end
    endtask

    task automatic test_tie();
        grant_log.delete();
        for (int r = 0; r < 2; r++) begin
            push_txn(1'b0, 24'h100000 + 24'(r), 32'hA0A1A2A3 + 32'(r));
            push_txn(1'b1, 24'h200000 + 24'(r), 32'hB0B1B2B3 + 32'(r));
            fork
                req_port(0, 24'h100000 + 24'(r));
                req_port(1, 24'h200000 + 24'(r));
            join
            wait_drain("tie");
        end
        checks++;
        if (grant_log.size() != 4) begin
            errors++;
            $display("FAIL tie_count: %0d grants, required 4", grant_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grant_log[i] != (i % 2)) begin
                    errors++;
                    $display("FAIL tie_order: grant %0d went to port %0d, required %0d", i, grant_log[i], i % 2);
                end
            end
        end
    endtask

    task automatic test_single();
        push_txn(1'b0, 24'h800001, 32'h44332211);
        req_port(0, 24'h800001);
        checks++;
        if (bus.busy !== 1'b1 || bus.cs_n !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: busy=%b cs_n=%b after accept, required 1 0", bus.busy, bus.cs_n);
        end
        wait_drain("single");
    endtask

    task automatic test_back_to_back();
        logic seen;
        push_txn(1'b1, 24'h0ABCDE, 32'hDEADBEEF);
        push_txn(1'b1, 24'h123456, 32'hCAFEF00D);
        req_port(1, 24'h0ABCDE);
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(posedge clk); #1;
            if (dbg_state == ST_DONE) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL b2b_done: DONE not reached within 500 cycles");
        end
        req_port(1, 24'h123456);
        wait_drain("back_to_back");
    endtask

    task automatic test_drop();
        int r0;
        r0 = 0;
        push_txn(1'b1, 24'h00FF00, 32'h0BADC0DE);
        req_port(1, 24'h00FF00);
        repeat (3) @(posedge clk);
        #1;
        bus.req0_addr = 24'h777777;
        bus.req0_valid = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.req0_ready) r0++;
        end
        bus.req0_valid = 1'b0;
        wait_drain("drop");
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.req0_ready) r0++;
        end
        checks++;
        if (r0 != 0) begin
            errors++;
            $display("FAIL drop_ready: %0d req0 ready pulses for a withdrawn request, required 0", r0);
        end
    endtask

    task automatic test_stall();
        int  base;
        int  held;
        logic ok;
        push_txn(1'b0, 24'h3C5A7E, 32'h89ABCDEF);
        base = tx_seen;
        req_port(0, 24'h3C5A7E);
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(posedge clk); #1;
            if (tx_seen >= base + 3) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_reach: only %0d bytes sent, required 3", tx_seen - base);
        end
        @(negedge clk);
        stall_hold = 1'b1;
        stall_dv = 0;
        held = tx_seen;
        repeat (20) @(posedge clk);
        @(negedge clk);
        stall_hold = 1'b0;
        checks++;
        if (stall_dv != 0 || tx_seen != held) begin
            errors++;
            $display("FAIL stall_tx: %0d bytes sent during stall, required 0", tx_seen - held);
        end
        wait_drain("stall");
    endtask

    task automatic test_reset_mid();
        int   base;
        logic ok;
        push_txn(1'b0, 24'h456789, 32'h13579BDF);
        base = tx_seen;
        req_port(0, 24'h456789);
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(posedge clk); #1;
            if (tx_seen >= base + 3) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstmid_reach: only %0d bytes sent, required 3", tx_seen - base);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.cs_n !== 1'b1 || bus.busy !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL rstmid_cs: cs_n=%b busy=%b state=%0d, required 1 0 %0d",
                     bus.cs_n, bus.busy, dbg_state, ST_IDLE);
        end
        checks++;
        if (bus.spi_tx_dv !== 1'b0 || bus.spi_tx_byte !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_tx: tx_dv=%b tx_byte=%02h, required 0 00", bus.spi_tx_dv, bus.spi_tx_byte);
        end
        checks++;
        if ({bus.req1_ready, bus.req0_ready, bus.resp1_valid, bus.resp0_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_hs: rdy=%b%b rv=%b%b, required 00 00",
                     bus.req1_ready, bus.req0_ready, bus.resp1_valid, bus.resp0_valid);
        end
        checks++;
        if (bus.resp0_data !== 32'h0 || bus.resp1_data !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_data: resp0=%08h resp1=%08h, required 0 0", bus.resp0_data, bus.resp1_data);
        end
        exp_mosi_q.delete();
        exp_resp_q.delete();
        miso_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        push_txn(1'b0, 24'h00A5A5, 32'h76543210);
        req_port(0, 24'h00A5A5);
        wait_drain("after_reset");
    endtask

    task automatic test_random();
        logic        p;
        logic [23:0] a;
        logic [31:0] w;
        for (int n = 0; n < 6; n++) begin
            p = 1'($urandom_range(0, 1));
            a = 24'($urandom);
            w = $urandom;
            push_txn(p, a, w);
            req_port(int'(p), a);
            wait_drain("random");
        end
    endtask

    // Watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Test sequence and report
    initial begin
        rst = 1'b1;
        test_reset();
        test_tie();
        test_single();
        test_back_to_back();
        test_drop();
        test_stall();
        test_reset_mid();
        test_random();
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
